cr_subcarrier_mapper: RTL and testbench

- Downstream consumer of the CR register block's ALLOC_VEC/STD outputs; sits between the QAM data stream and the IFFT input.
- Per OFDM symbol: snapshots the allocation vector, pulses VEC_LD to the register block, then emits N subcarrier samples in order.
- Allocated subcarriers carry the next upstream data sample; unallocated subcarriers carry zero.

---
 rtl/cr_pkg.sv | 36 +++
 rtl/cr_alloc_bit_sel.sv | 30 +++
 rtl/cr_subcarrier_mapper.sv | 147 ++++++++++++++
 tb/tb_cr_subcarrier_mapper.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_pkg.sv
// Shared definitions for the CR subcarrier mapper.
// Holds the STD codes, the subcarrier counts they select, the mapper FSM
// state type and the STD -> N decode helper.
package cr_pkg;

    // Standard-select codes from the register block
    localparam logic [1:0] STD_128  = 2'b00;
    localparam logic [1:0] STD_512  = 2'b01;
    localparam logic [1:0] STD_4096 = 2'b10;
    localparam logic [1:0] STD_RSVD = 2'b11;

    // Subcarrier counter / symbol length width (4096 needs 13 bits)
    localparam int KW = 13;

    localparam logic [KW-1:0] N_128  = 13'd128;
    localparam logic [KW-1:0] N_512  = 13'd512;
    localparam logic [KW-1:0] N_4096 = 13'd4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        MAP   = 2'd2,
        DRAIN = 2'd3
    } cr_state_e;

    // Reserved code decodes to 0; the FSM never starts a symbol with it.
    function automatic logic [KW-1:0] n_of_std(input logic [1:0] std);
        case (std)
            STD_128:  return N_128;
            STD_512:  return N_512;
            STD_4096: return N_4096;
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/cr_alloc_bit_sel.sv
// Allocation bit selector.
// Returns whether subcarrier k is allocated in the snapshot vector. The
// register block packs subcarrier 0 into the MSB of the active N bits, so
// the selected bit is snap[n-1-k]. Purely combinational wide mux.
// Ports:
//   snap_i  [VW-1:0]  allocation vector snapshot
//   n_i     [KW-1:0]  active symbol length N
//   k_i     [KW-1:0]  current subcarrier index
//   alloc_o           1 = subcarrier k carries data
module cr_alloc_bit_sel
    import cr_pkg::*;
#(
    parameter int VW = 4096
) (
    input  logic [VW-1:0] snap_i,
    input  logic [KW-1:0] n_i,
    input  logic [KW-1:0] k_i,
    output logic          alloc_o
);

    localparam int IW = $clog2(VW);

    logic [KW-1:0] idx;

    // k >= n wraps idx to a large value, which falls outside the vector
    // and reads as unallocated.
    assign idx     = n_i - k_i - KW'(1);
    assign alloc_o = (idx < KW'(VW)) ? snap_i[idx[IW-1:0]] : 1'b0;

endmodule

// File: rtl/cr_subcarrier_mapper.sv
// CR subcarrier mapper.
// Per OFDM symbol: snapshots ALLOC_VEC (pulsing VEC_LD), then emits N
// subcarrier samples in order. Allocated subcarriers take the next upstream
// sample, unallocated ones carry zero.
// Ports:
//   CLK_I, RST_I            clock, async active-high reset
//   DAT_I/CYC_I/STB_I/ACK_O upstream stream (beat = STB_I & ACK_O)
//   DAT_O/CYC_O/STB_O/ACK_I downstream stream (beat = STB_O & ACK_I)
//   EOS_O                   marks the beat carrying subcarrier N-1
//   STD, ALLOC_VEC          standard select / allocation vector inputs
//   VEC_LD                  one-cycle pulse while the snapshot is taken
//   STATE_O                 current FSM state (debug)
// Handshake: a beat transfers on a rising clock edge where valid and ready
// are both high; a presented output (DAT_O/EOS_O) holds while STB_O is high
// and ACK_I is low.
module cr_subcarrier_mapper
    import cr_pkg::*;
#(
    parameter int DW = 32,
    parameter int VW = 4096
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [DW-1:0] DAT_I,
    input  logic          CYC_I,
    input  logic          STB_I,
    output logic          ACK_O,
    output logic [DW-1:0] DAT_O,
    output logic          CYC_O,
    output logic          STB_O,
    input  logic          ACK_I,
    output logic          EOS_O,
    input  logic [1:0]    STD,
    input  logic [VW-1:0] ALLOC_VEC,
    output logic          VEC_LD,
    output logic [1:0]    STATE_O
);

    cr_state_e     state_q;
    logic [VW-1:0] snap_q;
    logic [KW-1:0] n_q;
    logic [KW-1:0] k_q;
    logic [KW-1:0] k_d;
    logic [DW-1:0] dat_q;
    logic          stb_q;
    logic          eos_q;
    logic          cyc_q;
    logic          vec_ld_q;

    logic alloc_k;
    logic room;      // output register free (empty or draining this cycle)
    logic in_range;
    logic last_k;
    logic take;      // output register loads subcarrier k this cycle
    logic start_ok;

    cr_alloc_bit_sel #(.VW(VW)) u_bit_sel (
        .snap_i  (snap_q),
        .n_i     (n_q),
        .k_i     (k_q),
        .alloc_o (alloc_k)
    );

    assign room     = !stb_q || ACK_I;
    assign in_range = k_q < n_q;
    assign last_k   = k_q == (n_q - KW'(1));
    assign k_d      = k_q + KW'(1);
    assign start_ok = CYC_I && (STD != STD_RSVD);

    // Upstream readiness does not depend on STB_I; an unallocated carrier
    // never consumes upstream data.
    assign ACK_O = (state_q == MAP) && alloc_k && room && in_range;
    assign take  = (state_q == MAP) && room && in_range && (!alloc_k || STB_I);

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q  <= IDLE;
            snap_q   <= '0;
            n_q      <= '0;
            k_q      <= '0;
            dat_q    <= '0;
            stb_q    <= 1'b0;
            eos_q    <= 1'b0;
            cyc_q    <= 1'b0;
            vec_ld_q <= 1'b0;
        end else begin
            vec_ld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q  <= LOAD;
                        vec_ld_q <= 1'b1;
                    end
                end
                LOAD: begin
                    // STD is re-checked here because N is latched from it.
                    if (STD == STD_RSVD) begin
                        state_q <= IDLE;
                    end else begin
                        snap_q  <= ALLOC_VEC;
                        n_q     <= n_of_std(STD);
                        k_q     <= '0;
                        cyc_q   <= 1'b1;
                        state_q <= MAP;
                    end
                end
                MAP: begin
                    if (take) begin
                        dat_q <= alloc_k ? DAT_I : '0;
                        stb_q <= 1'b1;
                        eos_q <= last_k;
                        k_q   <= k_d;
                        if (last_k) begin
                            state_q <= DRAIN;
                        end
                    end else if (ACK_I) begin
                        // pending beat drained with nothing ready behind it
                        stb_q <= 1'b0;
                        eos_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (stb_q && ACK_I) begin
                        stb_q <= 1'b0;
                        eos_q <= 1'b0;
                        cyc_q <= 1'b0;
                        if (start_ok) begin
                            state_q  <= LOAD;
                            vec_ld_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DAT_O   = dat_q;
    assign STB_O   = stb_q;
    assign EOS_O   = eos_q;
    assign CYC_O   = cyc_q;
    assign VEC_LD  = vec_ld_q;
    assign STATE_O = state_q;

endmodule

// File: tb/tb_cr_subcarrier_mapper.sv
module tb_cr_subcarrier_mapper;

  localparam int DW = 32;
  localparam int VW = 4096;

  logic          clk = 1'b0;
  logic          RST_I = 1'b1;
  logic [DW-1:0] DAT_I = '0;
  logic          CYC_I = 1'b0;
  logic          STB_I = 1'b0;
  logic          ACK_O;
  logic [DW-1:0] DAT_O;
  logic          CYC_O;
  logic          STB_O;
  logic          ACK_I = 1'b0;
  logic          EOS_O;
  logic [1:0]    STD = 2'b00;
  logic [VW-1:0] ALLOC_VEC = '0;
  logic          VEC_LD;
  logic [1:0]    STATE_O;

  cr_subcarrier_mapper #(.DW(DW), .VW(VW)) dut (
    .CLK_I     (clk),
    .RST_I     (RST_I),
    .DAT_I     (DAT_I),
    .CYC_I     (CYC_I),
    .STB_I     (STB_I),
    .ACK_O     (ACK_O),
    .DAT_O     (DAT_O),
    .CYC_O     (CYC_O),
    .STB_O     (STB_O),
    .ACK_I     (ACK_I),
    .EOS_O     (EOS_O),
    .STD       (STD),
    .ALLOC_VEC (ALLOC_VEC),
    .VEC_LD    (VEC_LD),
    .STATE_O   (STATE_O)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  logic [DW:0]   exp_q[$];   // {eos, data} per output beat
  logic [DW-1:0] src_q[$];   // upstream samples still to be offered
  int checks = 0;
  int failures = 0;
  int ack_pct = 100;
  int stb_pct = 100;
  int hold_at = -1;
  int hold_left = 0;
  int up_beats = 0;
  int out_beats = 0;
  int vec_ld_cnt = 0;
  int ack_seen = 0;
  int cyc_n = 0;
  int vld_cyc = 0;
  int last_beat_cyc = 0;
  bit lat_chk = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int n_of(input logic [1:0] std);
    case (std)
      2'b00:   return 128;
      2'b01:   return 512;
      default: return 4096;
    endcase
  endfunction

  function automatic logic [VW-1:0] rand_vec(input int density);
    logic [VW-1:0] v;
    for (int i = 0; i < VW; i++) v[i] = ($urandom_range(99) < density);
    return v;
  endfunction

  // Subcarrier k is allocated iff vec[N-1-k]; allocated carriers take the
  // next upstream sample in order, the rest carry zero.
  task automatic prepare(input logic [1:0] std, input logic [VW-1:0] vec, input bit counting);
    int n;
    int cnt;
    n = n_of(std);
    cnt = 0;
    STD = std;
    ALLOC_VEC = vec;
    for (int k = 0; k < n; k++) begin
      logic [DW-1:0] d;
      d = '0;
      if (vec[n-1-k]) begin
        cnt++;
        d = counting ? DW'(cnt) : DW'($urandom);
        src_q.push_back(d);
      end
      exp_q.push_back({(k == n - 1), d});
    end
    out_beats = 0;
    up_beats = 0;
  endtask

  // ---------------- driver processes ----------------
  initial begin : ack_driver
    forever begin
      @(posedge clk); #1;
      ACK_I = ($urandom_range(99) < ack_pct);
    end
  end

  initial begin : upstream_driver
    bit fire;
    forever begin
      @(negedge clk);
      fire = STB_I && ACK_O;
      @(posedge clk);
      if (fire && !RST_I && src_q.size() > 0) begin
        void'(src_q.pop_front());
        up_beats++;
      end
      #1;
      if (hold_left > 0 && up_beats == hold_at) begin
        STB_I = 1'b0;
        DAT_I = $urandom;
        hold_left--;
        if (hold_left == 0) begin
          check("stall_k_hold_beats", out_beats, 5);
          check("stall_stb_dropped", STB_O, 0);
        end
      end else if (src_q.size() > 0 && $urandom_range(99) < stb_pct) begin
        STB_I = 1'b1;
        DAT_I = src_q[0];
      end else begin
        STB_I = 1'b0;
        DAT_I = $urandom;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [DW:0] exp_v;
    logic [DW:0] held_v;
    bit held_pend;
    bit first_pend;
    held_pend = 0;
    first_pend = 0;
    held_v = '0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (RST_I) begin
        held_pend = 0;
        first_pend = 0;
      end else begin
        if (held_pend) check("hold_stable", {STB_O, EOS_O, DAT_O}, {1'b1, held_v});
        if (VEC_LD) begin
          vec_ld_cnt++;
          vld_cyc = cyc_n;
          first_pend = 1;
        end else if (first_pend && STB_O) begin
          first_pend = 0;
          if (lat_chk) check("first_latency", cyc_n - vld_cyc, 2);
        end
        if (ACK_O) ack_seen++;
        if (STB_O && ACK_I) begin
          check("exp_available", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check("beat_eos_data", {EOS_O, DAT_O}, exp_v);
          end
          out_beats++;
          last_beat_cyc = cyc_n;
        end
        held_pend = STB_O && !ACK_I;
        held_v = {EOS_O, DAT_O};
      end
    end
  end

  // ---------------- sequencing tasks ----------------
  task automatic wait_vec_ld(input int vld0);
    for (int i = 0; i < 20 && vec_ld_cnt == vld0; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    check("symbol_drained", exp_q.size(), 0);
    exp_q.delete();
    src_q.delete();
  endtask

  task automatic run_symbol(input logic [1:0] std, input logic [VW-1:0] vec,
                            input int ack_p, input int stb_p, input bit counting,
                            input bit mess);
    int vld0;
    int n;
    n = n_of(std);
    prepare(std, vec, counting);
    ack_pct = ack_p;
    stb_pct = stb_p;
    vld0 = vec_ld_cnt;
    @(posedge clk); #1;
    CYC_I = 1'b1;
    wait_vec_ld(vld0);
    if (mess) begin
      // snapshot already taken: these must not disturb the current symbol
      ALLOC_VEC = ~ALLOC_VEC;
      STD = 2'b11;
    end else begin
      CYC_I = 1'b0;
    end
    wait_empty(n * 20 + 100);
    repeat (4) @(posedge clk);
    #1;
    check("vec_ld_once", vec_ld_cnt - vld0, 1);
    check("cyc_o_low_after", CYC_O, 0);
    check("stb_o_low_after", STB_O, 0);
    check("state_idle_after", STATE_O, cr_pkg::IDLE);
    CYC_I = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin : main
    logic [VW-1:0] v;
    int vld0;
    int ack0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dat_o", DAT_O, 0);
    check("rst_stb_o", STB_O, 0);
    check("rst_cyc_o", CYC_O, 0);
    check("rst_eos_o", EOS_O, 0);
    check("rst_ack_o", ACK_O, 0);
    check("rst_vec_ld", VEC_LD, 0);
    RST_I = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 128-carrier symbol with the reference allocation, counting data
    v = '0;
    v[127:0] = 128'hFFFF0000_0000FFFF_00000000_00000001;
    lat_chk = 1;
    run_symbol(2'b00, v, 100, 100, 1'b1, 1'b0);
    lat_chk = 0;
    check("throughput_128", last_beat_cyc - vld_cyc, 129);

    // 512 carriers, nothing allocated: no upstream handshakes at all
    ack0 = ack_seen;
    run_symbol(2'b01, '0, 60, 100, 1'b0, 1'b0);
    check("zero_alloc_no_ack", ack_seen - ack0, 0);
    check("zero_alloc_beats", out_beats, 512);

    // 4096 carriers, all allocated, downstream stalling half the time
    run_symbol(2'b10, '1, 50, 100, 1'b0, 1'b0);
    check("all_ones_consumed", up_beats, 4096);
    check("all_ones_beats", out_beats, 4096);

    // upstream withheld for 10 cycles at allocated carrier 5
    hold_at = 5;
    hold_left = 10;
    run_symbol(2'b00, v, 100, 100, 1'b1, 1'b0);
    check("stall_hold_used", hold_left, 0);
    hold_at = -1;

    // ALLOC_VEC rewritten and STD reserved during MAP, CYC_I left high
    run_symbol(2'b00, rand_vec(50), 100, 100, 1'b0, 1'b1);
    STD = 2'b00;

    // randomized symbols
    for (int i = 0; i < 4; i++) begin
      run_symbol(2'($urandom_range(1)), rand_vec($urandom_range(100)),
                 $urandom_range(100, 30), $urandom_range(100, 30), 1'b0, 1'b0);
    end

    // reset around carrier 60 of a 128-carrier symbol
    prepare(2'b00, rand_vec(50), 1'b0);
    ack_pct = 100;
    stb_pct = 100;
    vld0 = vec_ld_cnt;
    @(posedge clk); #1;
    CYC_I = 1'b1;
    wait_vec_ld(vld0);
    for (int i = 0; i < 500 && out_beats < 60; i++) begin
      @(posedge clk); #1;
    end
    check("reached_carrier_60", out_beats >= 60, 1);
    @(negedge clk); #2;
    RST_I = 1'b1;
    #1;
    check("async_rst_dat_o", DAT_O, 0);
    check("async_rst_stb_o", STB_O, 0);
    check("async_rst_cyc_o", CYC_O, 0);
    check("async_rst_eos_o", EOS_O, 0);
    check("async_rst_ack_o", ACK_O, 0);
    check("async_rst_vec_ld", VEC_LD, 0);
    exp_q.delete();
    src_q.delete();
    prepare(2'b00, rand_vec(50), 1'b0);
    vld0 = vec_ld_cnt;
    @(posedge clk); #1;
    RST_I = 1'b0;
    wait_vec_ld(vld0);
    CYC_I = 1'b0;
    wait_empty(2000);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_vec_ld_once", vec_ld_cnt - vld0, 1);
    check("post_rst_full_symbol", out_beats, 128);
    check("post_rst_cyc_o_low", CYC_O, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
